// File: rtl/galaga_pkg.sv
// galaga_pkg: constants and helpers shared by the Galaga display path.
//   - 640x480@60 horizontal/vertical timing (visible, porch, sync, total)
//   - 3-bit pixel-state codes produced by the renderer
//   - sync_bits_t: the {hsync, vsync, de} bundle carried down the delay line
//   - palette(): pixel-state code -> 12-bit {R,G,B} nibbles
package galaga_pkg;

  // Horizontal timing, in pixels
  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;                   // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;                 // 752, exclusive

  // Vertical timing, in lines
  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;                   // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;                 // 492, exclusive

  // Pixel-state codes shared with the renderer
  localparam logic [2:0] PS_BACKGROUND    = 3'b000;
  localparam logic [2:0] PS_PLAYER        = 3'b001;
  localparam logic [2:0] PS_PLAYER_BULLET = 3'b010;
  localparam logic [2:0] PS_ENEMY_BULLET  = 3'b011;
  localparam logic [2:0] PS_ENEMY         = 3'b100;
  localparam logic [2:0] PS_MAGENTA       = 3'b101;
  localparam logic [2:0] PS_CYAN          = 3'b110;
  localparam logic [2:0] PS_WHITE         = 3'b111;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bits_t;

  function automatic logic [11:0] palette(input logic [2:0] code);
    logic [11:0] rgb;
    case (code)
      PS_BACKGROUND:    rgb = 12'h000;
      PS_PLAYER:        rgb = 12'h00F;
      PS_PLAYER_BULLET: rgb = 12'h0F0;
      PS_ENEMY_BULLET:  rgb = 12'hFF0;
      PS_ENEMY:         rgb = 12'hF00;
      PS_MAGENTA:       rgb = 12'hF0F;
      PS_CYAN:          rgb = 12'h0FF;
      PS_WHITE:         rgb = 12'hFFF;
      default:          rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: WIDTH x DEPTH shift register advancing only when en is high.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - shift enable (one pulse per pixel tick)
//   reset_value  - value every stage takes while rst is high
//   d            - data entering stage 0
//   q            - output of the last stage
//   last_d       - data currently presented to the last stage (what q takes on the next shift)
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] reset_value,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] last_d
);

  logic [WIDTH-1:0] stage_in  [DEPTH];
  logic [WIDTH-1:0] stage_reg [DEPTH];

  assign stage_in[0] = d;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi > 0) begin : g_chain
        assign stage_in[gi] = stage_reg[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg[gi] <= reset_value;
        end else if (en) begin
          stage_reg[gi] <= stage_in[gi];
        end
      end
    end
  endgenerate

  assign q      = stage_reg[DEPTH-1];
  assign last_d = stage_in[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 scan generator and colour back end.
// Ports:
//   i_clk, i_rst        - system clock, asynchronous active-high reset
//   i_pixelState        - renderer's registered pixel-state code
//   o_n_PixelPos_x/y    - scan counters (0..799 / 0..524) to the renderer
//   o_pixelTick         - one-clock pulse each time the counters advance
//   o_frameStart        - one-clock pulse on the tick that loads (0,0)
//   o_vblank            - y in the vertical blanking region (y >= 480)
//   o_hsync/o_vsync/o_de- sync and display enable, delayed PIPE_DELAY ticks
//   o_red/green/blue    - 4-bit colour channels, aligned with sync/de
module vga_timing_gen
  import galaga_pkg::*;
#(
  parameter int   CLK_DIV     = 2,
  parameter int   PIPE_DELAY  = 1,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_pixelState,
  output logic [9:0] o_n_PixelPos_x,
  output logic [9:0] o_n_PixelPos_y,
  output logic       o_pixelTick,
  output logic       o_frameStart,
  output logic       o_vblank,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
  localparam sync_bits_t       SYNC_IDLE = '{hsync: !SYNC_ACTIVE, vsync: !SYNC_ACTIVE, de: 1'b0};

  logic [DIV_W-1:0] div_reg, div_next;
  logic [9:0]       x_reg, x_next;
  logic [9:0]       y_reg, y_next;
  logic             tick_reg, tick_next;
  logic             frame_reg, frame_next;
  logic [11:0]      rgb_reg, rgb_next;

  sync_bits_t raw_bits;
  sync_bits_t out_bits;
  sync_bits_t pre_bits;
  logic       unused_pre_sync;

  // Counter update. The tick pulse is registered together with the new
  // coordinate, so o_pixelTick is high exactly while a fresh (x,y) is shown.
  always_comb begin
    tick_next  = (div_reg == DIV_LAST);
    div_next   = tick_next ? '0 : div_reg + DIV_W'(1);
    x_next     = x_reg;
    y_next     = y_reg;
    frame_next = 1'b0;
    if (tick_next) begin
      if (x_reg == X_LAST) begin
        x_next = '0;
        if (y_reg == Y_LAST) begin
          y_next     = '0;
          frame_next = 1'b1;
        end else begin
          y_next = y_reg + 10'd1;
        end
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  // Sync/de for the coordinate currently presented to the renderer.
  always_comb begin
    raw_bits       = SYNC_IDLE;
    raw_bits.hsync = ((x_reg >= 10'(H_SYNC_START)) && (x_reg < 10'(H_SYNC_END)))
                     ? SYNC_ACTIVE : !SYNC_ACTIVE;
    raw_bits.vsync = ((y_reg >= 10'(V_SYNC_START)) && (y_reg < 10'(V_SYNC_END)))
                     ? SYNC_ACTIVE : !SYNC_ACTIVE;
    raw_bits.de    = (x_reg < 10'(H_VISIBLE)) && (y_reg < 10'(V_VISIBLE));
  end

  sync_delay_line #(
    .WIDTH($bits(sync_bits_t)),
    .DEPTH(PIPE_DELAY)
  ) u_sync_delay (
    .clk         (i_clk),
    .rst         (i_rst),
    .en          (tick_next),
    .reset_value (SYNC_IDLE),
    .d           (raw_bits),
    .q           (out_bits),
    .last_d      (pre_bits)
  );

  // Only the de bit of the last-stage input gates colour.
  assign unused_pre_sync = pre_bits.hsync ^ pre_bits.vsync;

  // Colour loads on the same edge as the last delay stage, so it lines up
  // with o_de; blanking forces black regardless of the pixel state.
  always_comb begin
    rgb_next = rgb_reg;
    if (tick_next) begin
      rgb_next = pre_bits.de ? palette(i_pixelState) : 12'h000;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      tick_reg  <= 1'b0;
      frame_reg <= 1'b0;
      rgb_reg   <= 12'h000;
    end else begin
      div_reg   <= div_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      tick_reg  <= tick_next;
      frame_reg <= frame_next;
      rgb_reg   <= rgb_next;
    end
  end

  assign o_n_PixelPos_x = x_reg;
  assign o_n_PixelPos_y = y_reg;
  assign o_pixelTick    = tick_reg;
  assign o_frameStart   = frame_reg;
  assign o_vblank       = (y_reg >= 10'(V_VISIBLE));
  assign o_hsync        = out_bits.hsync;
  assign o_vsync        = out_bits.vsync;
  assign o_de           = out_bits.de;
  assign o_red          = rgb_reg[11:8];
  assign o_green        = rgb_reg[7:4];
  assign o_blue         = rgb_reg[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives vga_timing_gen with a behavioural renderer and
// checks every clock against a scan model computed from cycle counts.
module tb_vga_timing_gen;

  localparam int CLK_DIV    = 2;
  localparam int PIPE_DELAY = 1;
  localparam int FRAME_PIX  = 800 * 525;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] pix_state = 3'b000;
  logic [9:0] o_n_PixelPos_x, o_n_PixelPos_y;
  logic       o_pixelTick, o_frameStart, o_vblank;
  logic       o_hsync, o_vsync, o_de;
  logic [3:0] o_red, o_green, o_blue;

  vga_timing_gen #(
    .CLK_DIV    (CLK_DIV),
    .PIPE_DELAY (PIPE_DELAY),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pixelState   (pix_state),
    .o_n_PixelPos_x (o_n_PixelPos_x),
    .o_n_PixelPos_y (o_n_PixelPos_y),
    .o_pixelTick    (o_pixelTick),
    .o_frameStart   (o_frameStart),
    .o_vblank       (o_vblank),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync),
    .o_de           (o_de),
    .o_red          (o_red),
    .o_green        (o_green),
    .o_blue         (o_blue)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          mode  = 0;
  int unsigned seed_a = 1, seed_b = 1, seed_c = 0;
  int          n = 0;        // clock edges since reset release
  int          cyc = 0;      // absolute clock edges
  logic        junk_en = 1'b0;
  int          hs_fall = -1, de_rise = -1, f00_cnt = 0;
  logic        prev_hs = 1'b1, prev_de = 1'b0;
  logic [11:0] pal [8] = '{12'h000, 12'h00F, 12'h0F0, 12'hFF0,
                           12'hF00, 12'hF0F, 12'h0FF, 12'hFFF};

  // Renderer picture as a function of the scan coordinate.
  function automatic logic [2:0] render(input int m, input int x, input int y);
    case (m)
      0:       return (x == 10 && y == 5) ? 3'b100 : 3'b000;
      1:       return 3'b111;
      2:       return 3'(x % 8);
      default: return 3'((x * seed_a + y * seed_b + seed_c) % 8);
    endcase
  endfunction

  // Renderer with 1-clk registered latency. In the cycle that is not followed
  // by a sampling tick it outputs junk, which the DUT must ignore.
  always @(posedge clk) begin
    if (o_pixelTick || !junk_en)
      pix_state <= render(mode, int'(o_n_PixelPos_x), int'(o_n_PixelPos_y));
    else
      pix_state <= 3'($urandom_range(0, 7));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_now();
    int ticks, p, ex, ey, q, qx, qy;
    logic tick_e, frame_e, hs_e, vs_e, de_e;
    logic [11:0] rgb_e;
    ticks   = n / CLK_DIV;
    tick_e  = (n > 0) && (n % CLK_DIV == 0);
    p       = ticks % FRAME_PIX;
    ex      = p % 800;
    ey      = p / 800;
    frame_e = tick_e && (p == 0);
    if (ticks < PIPE_DELAY) begin
      hs_e = 1'b1; vs_e = 1'b1; de_e = 1'b0; rgb_e = 12'h000;
    end else begin
      q     = (ticks - PIPE_DELAY) % FRAME_PIX;
      qx    = q % 800;
      qy    = q / 800;
      hs_e  = !(qx >= 656 && qx <= 751);
      vs_e  = !(qy >= 490 && qy <= 491);
      de_e  = (qx < 640) && (qy < 480);
      rgb_e = de_e ? pal[render(mode, qx, qy)] : 12'h000;
    end
    chk("x", 32'(o_n_PixelPos_x), 32'(ex));
    chk("y", 32'(o_n_PixelPos_y), 32'(ey));
    chk("tick", 32'(o_pixelTick), 32'(tick_e));
    chk("frame_start", 32'(o_frameStart), 32'(frame_e));
    chk("vblank", 32'(o_vblank), 32'(ey >= 480));
    chk("hsync", 32'(o_hsync), 32'(hs_e));
    chk("vsync", 32'(o_vsync), 32'(vs_e));
    chk("de", 32'(o_de), 32'(de_e));
    chk("rgb", 32'({o_red, o_green, o_blue}), 32'(rgb_e));
    if (!rst) begin
      if (prev_hs && !o_hsync) begin
        if (hs_fall >= 0) chk("hsync_period_clk", 32'(cyc - hs_fall), 32'd1600);
        hs_fall = cyc;
      end
      if (!prev_hs && o_hsync && hs_fall >= 0) chk("hsync_low_clk", 32'(cyc - hs_fall), 32'd192);
      if (!prev_de && o_de) de_rise = cyc;
      if (prev_de && !o_de && de_rise >= 0) chk("de_high_clk", 32'(cyc - de_rise), 32'd1280);
      if ({o_red, o_green, o_blue} == 12'hF00) f00_cnt++;
    end
    prev_hs = o_hsync;
    prev_de = o_de;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) n++;
    @(negedge clk);
    junk_en = !rst && (n >= 1);
    check_now();
  endtask

  // Called at a falling edge: hold reset for some cycles, then release.
  task automatic do_reset(input int m, input int hold);
    rst     = 1'b1;
    n       = 0;
    junk_en = 1'b0;
    mode    = m;
    seed_a  = $urandom_range(1, 97);
    seed_b  = $urandom_range(1, 97);
    seed_c  = $urandom_range(0, 7);
    repeat (hold) step();
    rst     = 1'b0;
    n       = 0;
    junk_en = 1'b0;
    hs_fall = -1;
    de_rise = -1;
    prev_hs = 1'b1;
    prev_de = 1'b0;
    f00_cnt = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check_now();

    // Single enemy pixel at (10,5), then run on to (300,10) for a mid-line reset.
    do_reset(0, $urandom_range(1, 4));
    repeat (16600) step();
    chk("align_f00_clks", 32'(f00_cnt), 32'd2);
    chk("pre_reset_x", 32'(o_n_PixelPos_x), 32'd300);
    chk("pre_reset_y", 32'(o_n_PixelPos_y), 32'd10);
    #2 rst = 1'b1;
    n = 0;
    #1 check_now();
    @(negedge clk);

    // Constant white (blanking), palette sweep, then randomised pictures.
    do_reset(1, $urandom_range(1, 4));
    repeat (3400 + $urandom_range(0, 1600)) step();
    do_reset(2, $urandom_range(1, 4));
    repeat (3400 + $urandom_range(0, 1600)) step();
    for (int k = 0; k < 3; k++) begin
      do_reset(3, $urandom_range(1, 4));
      repeat (3400 + $urandom_range(0, 1600)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
